// File: rtl/mips_multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : mips_multicycle_control
// Description : Control FSM sequencing a multicycle MIPS datapath, stalling on
//               the memory ready handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed by the ULA and committed together with the IR
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_R_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDI_EXEC;
                end else begin
                    state_d    = S_FETCH;
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : tb_mips_multicycle_control
// Description : Randomised self-checking bench against an instruction-level
//               step model of the multicycle control sequence.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_control;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;

    typedef int int_q_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [17:0] w_outs;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_control dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .instr_done    (instr_done),
        .state         (state)
    );

    always #5 clock = ~clock;

    assign w_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op, instr_done};

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {C_OP_RTYPE, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_J, C_OP_ADDI};
    endfunction

    // Instruction -> ordered list of steps it walks through, starting at FETCH
    function automatic int_q_t steps_for(input logic [5:0] op);
        int_q_t q;
        if (op == C_OP_LW)         q = '{1, 2, 3, 4, 5};
        else if (op == C_OP_SW)    q = '{1, 2, 3, 6};
        else if (op == C_OP_RTYPE) q = '{1, 2, 7, 8};
        else if (op == C_OP_BEQ)   q = '{1, 2, 9};
        else if (op == C_OP_J)     q = '{1, 2, 10};
        else if (op == C_OP_ADDI)  q = '{1, 2, 11, 12};
        else                       q = '{1, 2};
        return q;
    endfunction

    function automatic int base_latency(input logic [5:0] op);
        if (op == C_OP_LW) return 5;
        if (op == C_OP_SW || op == C_OP_RTYPE || op == C_OP_ADDI) return 4;
        if (op == C_OP_BEQ || op == C_OP_J) return 3;
        return 2;
    endfunction

    // Expected control word for one step, straight from the step description table
    function automatic logic [17:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, dn;
        logic [1:0] asb, aop, pcs;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, dn} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            2:  begin asb = 2'b11; ill = !is_legal(op); dn = !is_legal(op); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin mw = 1; iod = 1; dn = rdy; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; dn = 1; end
            10: begin pw = 1; pcs = 2'b10; dn = 1; end
            11: begin asa = 1; asb = 2'b10; end
            12: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill, dn};
    endfunction

    // Runs one instruction from FETCH. stall<0: random ready everywhere;
    // stall>=0: ready held low for that many cycles in the data-memory wait step.
    task automatic run_instr(input logic [5:0] op, input int stall);
        int_q_t seq;
        int idx, lows, mem_lows, cycles, done_cnt, st;
        logic rdy;
        bit waits;
        seq = steps_for(op);
        idx = 0; lows = 0; mem_lows = 0; cycles = 0; done_cnt = 0;
        while (idx < seq.size()) begin
            st    = seq[idx];
            waits = (st == 1 || st == 4 || st == 6);
            if (stall < 0)                          rdy = 1'($urandom_range(0, 1));
            else if (waits && st != 1 && mem_lows < stall) rdy = 1'b0;
            else                                    rdy = 1'b1;
            mem_ready = rdy;
            opcode    = op;
            #1;
            n_checks++;
            if (state !== 4'(st)) begin
                n_fail++;
                $display("FAIL state op=%h cyc=%0d: got %0d expected %0d", op, cycles, state, st);
            end
            n_checks++;
            if (w_outs !== exp_out(st, op, rdy)) begin
                n_fail++;
                $display("FAIL outputs op=%h step=%0d rdy=%b: got %b expected %b",
                         op, st, rdy, w_outs, exp_out(st, op, rdy));
            end
            n_checks++;
            if ((mem_read && mem_write) || (reg_write && (pc_write || pc_write_cond))) begin
                n_fail++;
                $display("FAIL invariant op=%h step=%0d: got outputs %b expected no conflict",
                         op, st, w_outs);
            end
            if (instr_done === 1'b1) done_cnt++;
            if (waits && !rdy) begin
                lows++;
                if (st != 1) mem_lows++;
            end else begin
                idx++;
            end
            cycles++;
            @(posedge clock);
            @(negedge clock);
            if (cycles > 300) begin
                n_fail++;
                $display("FAIL timeout op=%h: got %0d cycles expected completion", op, cycles);
                break;
            end
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL instr_done_count op=%h: got %0d expected 1", op, done_cnt);
        end
        n_checks++;
        if (cycles != base_latency(op) + lows) begin
            n_fail++;
            $display("FAIL latency op=%h: got %0d expected %0d", op, cycles, base_latency(op) + lows);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1;
        @(posedge clock); @(posedge clock); @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || w_outs !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got state %0d outs %b expected state 0 outs 0", state, w_outs);
        end
        @(posedge clock); @(negedge clock);
        #1;
        n_checks++;
        if (state !== 4'd1 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_fetch: got state %0d irw %b pcw %b asb %b expected 1 1 1 01",
                     state, ir_write, pc_write, alu_src_b);
        end
    endtask

    task automatic test_rtype();          run_instr(C_OP_RTYPE, 0); endtask
    task automatic test_lw_stall();       run_instr(C_OP_LW, 3);    endtask
    task automatic test_sw();             run_instr(C_OP_SW, 2);    endtask
    task automatic test_addi();           run_instr(C_OP_ADDI, 0);  endtask
    task automatic test_illegal();        run_instr(6'h3F, 0);      endtask

    task automatic test_branch_jump();
        run_instr(C_OP_BEQ, 0);
        run_instr(C_OP_J, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        logic [5:0] legal_ops [6];
        legal_ops = '{C_OP_RTYPE, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_J, C_OP_ADDI};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else                           op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_midway();
        opcode = C_OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); @(negedge clock);
        end
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd4 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midway_mem_read: got state %0d mem_read %b expected 4 1", state, mem_read);
        end
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        #1;
        n_checks++;
        if (state !== 4'd0 || w_outs !== 18'd0) begin
            n_fail++;
            $display("FAIL midway_abort: got state %0d outs %b expected state 0 outs 0", state, w_outs);
        end
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        n_checks++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL midway_restart: got state %0d expected 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_branch_jump();
        test_addi();
        test_illegal();
        test_back_to_back();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
